// File: rtl/pc_pkg.sv
// pc_pkg: shared state/redirect encodings for the fetch unit
package pc_pkg;
  localparam int RV32_INSTR_BYTES = 4;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, TRAP} fetch_state_t;
  typedef enum logic [1:0] {NONE, BRANCH, JUMP, RET} redir_kind_t;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack with saturating occupancy count
module pc_ras #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] din,
  output logic [XLEN-1:0] top,
  output logic            empty
);
  localparam int AW = $clog2(DEPTH);
  logic [XLEN-1:0] mem [DEPTH];
  logic [AW-1:0]   ptr;
  logic [AW:0]     count;
  assign top   = mem[ptr - AW'(1)];
  assign empty = count == '0;
  // pointer wraps so a push onto a full stack overwrites the oldest entry
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr   <= ptr + AW'(1);
      count <= (count == (AW+1)'(DEPTH)) ? count : count + (AW+1)'(1);
    end else if (pop && !empty) begin
      ptr   <= ptr - AW'(1);
      count <= count - (AW+1)'(1);
    end
  end
  // entry storage needs no reset; occupancy guards every read
  always_ff @(posedge clk) begin
    if (push) mem[ptr] <= din;
  end
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and fetch handshake controller with redirects and RAS
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              INSTR_BYTES  = RV32_INSTR_BYTES,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            stall,
  input  logic            branch_en,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] imm,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            call,
  input  logic            ret,
  input  logic            fetch_ack,
  output logic            fetch_req,
  output logic [XLEN-1:0] fetch_addr,
  output logic [XLEN-1:0] pc_val,
  output logic            misalign,
  output logic            ras_empty,
  output logic            ras_underflow
);
  localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);
  localparam logic [XLEN-1:0] MASK = XLEN'(INSTR_BYTES - 1);
  fetch_state_t    state, state_nx;
  redir_kind_t     kind;
  logic [XLEN-1:0] seq, ras_top, cur_tgt, pend_tgt, apply_tgt;
  logic            pend_valid, accept, apply, bad;
  assign fetch_req  = state == FETCH;
  assign fetch_addr = pc_val;
  assign misalign   = state == TRAP;
  pc_ras #(.XLEN(XLEN), .DEPTH(RAS_DEPTH)) u_ras (
    .clk   (clk),
    .clr   (clr),
    .push  (accept && kind == JUMP && call),
    .pop   (accept && kind == RET),
    .din   (seq),
    .top   (ras_top),
    .empty (ras_empty)
  );
  // redirect selection, apply point and next-state decode
  always_comb begin
    seq       = pc_val + STEP;
    kind      = ret ? RET : jump ? JUMP : (branch_en && branch_taken) ? BRANCH : NONE;
    accept    = (state == FETCH || state == HOLD) && !pend_valid && kind != NONE;
    cur_tgt   = kind == RET ? (ras_empty ? seq : ras_top) : kind == JUMP ? jump_target : pc_val + imm;
    apply     = (state == FETCH && fetch_ack) || (state == HOLD && !stall);
    apply_tgt = pend_valid ? pend_tgt : accept ? cur_tgt : state == FETCH ? seq : pc_val;
    bad       = |(apply_tgt & MASK);
    state_nx  = state == IDLE ? FETCH : !apply ? state : bad ? TRAP : (state == FETCH && stall) ? HOLD : FETCH;
  end
  // state register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= state_nx;
  end
  // PC, pending redirect and underflow pulse; a misaligned target leaves the PC untouched
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pc_val        <= RESET_VECTOR;
      pend_valid    <= 1'b0;
      pend_tgt      <= '0;
      ras_underflow <= 1'b0;
    end else begin
      ras_underflow <= accept && kind == RET && ras_empty;
      if (apply && !bad) pc_val <= apply_tgt;
      if (apply) pend_valid <= 1'b0;
      else if (accept) begin
        pend_valid <= 1'b1;
        pend_tgt   <= cur_tgt;
      end
    end
  end
endmodule
